// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI responder that emulates a 12-bit ADC for loopback and self-test.
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_sck, i_cs, i_mosi   asynchronous SPI lines from the master (CS active-low)
//   o_miso                responder data, MSB first, changes on SCK falling edges
//   i_sample_data/valid   one-deep holding register write port, o_sample_ready = empty
//   o_busy                frame in progress
//   o_frame_done/o_rx_valid  1-cycle pulse on a complete frame, o_rx_data = captured MOSI word
//   o_underrun            1-cycle pulse when a frame starts with the holding register empty
//   o_short_frame         1-cycle pulse when CS rises before FRAME_LEN rising edges
// Optional feature macro SPI_RESP_PATTERN_EN: on underrun send last_sent+1 (test ramp)
// instead of repeating last_sent.
module spi_adc_responder #(
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 4,
    parameter int FRAME_LEN  = DATA_W + LEAD_ZEROS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_sck,
    input  logic                 i_cs,
    input  logic                 i_mosi,
    output logic                 o_miso,
    input  logic [DATA_W-1:0]    i_sample_data,
    input  logic                 i_sample_valid,
    output logic                 o_sample_ready,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic [FRAME_LEN-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_underrun,
    output logic                 o_short_frame
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, OVER} state_t;
    state_t r_state, w_next;
    // [0] first sync stage, [1] second stage, [2] delayed copy for edge detection
    logic [2:0] r_sck_sync, r_cs_sync;
    logic [1:0] r_mosi_sync;
    // Marks when the second sync stage holds a real pin sample rather than its reset value
    logic [1:0] r_flush;
    logic r_armed;
    logic [FRAME_LEN-1:0] r_tx_sh, r_rx_sh, r_rx_data;
    logic [CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_word, r_last, r_hold;
    logic r_hold_full, r_frame_done, r_short, r_underrun;
    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_start, w_end, w_rx_edge, w_wr;
    logic [DATA_W-1:0] w_under_word, w_word;
    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_start    = (r_state == IDLE) & w_cs_fall & r_armed;
    assign w_end      = (r_state != IDLE) & w_cs_rise;
    assign w_rx_edge  = (r_state == ACTIVE) & w_sck_rise;
    assign w_wr       = i_sample_valid & ~r_hold_full;
`ifdef SPI_RESP_PATTERN_EN
    assign w_under_word = r_last + DATA_W'(1);
`else
    assign w_under_word = r_last;
`endif
    assign w_word = r_hold_full ? r_hold : w_under_word;
    assign o_miso         = (r_state == ACTIVE) & r_tx_sh[FRAME_LEN-1];
    assign o_busy         = r_state != IDLE;
    assign o_sample_ready = ~r_hold_full;
    assign o_frame_done   = r_frame_done;
    assign o_rx_valid     = r_frame_done;
    assign o_rx_data      = r_rx_data;
    assign o_underrun     = r_underrun;
    assign o_short_frame  = r_short;
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_start) w_next = ACTIVE;
        else if (w_end) w_next = IDLE;
        else if (w_rx_edge && r_cnt == CNT_W'(FRAME_LEN - 1)) w_next = OVER;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sck_sync   <= '0;
            r_cs_sync    <= '1;
            r_mosi_sync  <= '0;
            r_flush      <= '0;
            r_armed      <= 1'b0;
            r_tx_sh      <= '0;
            r_rx_sh      <= '0;
            r_rx_data    <= '0;
            r_cnt        <= '0;
            r_word       <= '0;
            r_last       <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_frame_done <= 1'b0;
            r_short      <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_sck_sync   <= {r_sck_sync[1:0], i_sck};
            r_cs_sync    <= {r_cs_sync[1:0], i_cs};
            r_mosi_sync  <= {r_mosi_sync[0], i_mosi};
            r_flush      <= {r_flush[0], 1'b1};
            r_armed      <= r_armed | (r_flush[1] & r_cs_sync[1]);
            r_frame_done <= 1'b0;
            r_short      <= 1'b0;
            r_underrun   <= 1'b0;
            if (w_start) begin
                r_tx_sh    <= {{LEAD_ZEROS{1'b0}}, w_word};
                r_word     <= w_word;
                r_underrun <= ~r_hold_full;
                r_rx_sh    <= '0;
                r_cnt      <= '0;
            end else if (w_end) begin
                if (r_cnt == CNT_W'(FRAME_LEN)) begin
                    r_rx_data    <= r_rx_sh;
                    r_frame_done <= 1'b1;
                end else begin
                    r_short <= 1'b1;
                end
                r_last <= r_word;
                r_cnt  <= '0;
            end else if (r_state == ACTIVE) begin
                if (w_sck_rise) begin
                    r_rx_sh <= {r_rx_sh[FRAME_LEN-2:0], r_mosi_sync[1]};
                    r_cnt   <= r_cnt + 1'b1;
                end
                if (w_sck_fall) r_tx_sh <= r_tx_sh << 1;
            end
            // A write coinciding with a frame start lands in the register for the next frame
            r_hold_full <= (r_hold_full & ~w_start) | w_wr;
            if (w_wr) r_hold <= i_sample_data;
        end
    end
endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

- SPI responder (slave) that emulates the 12-bit ADC read by the design's SPI master.
- Gives a loopback and self-test target: drives MISO from a one-deep sample holding register and captures the MOSI word of each frame.
- Runs on the system clock; oversamples and synchronises the incoming SCK/CS/MOSI lines, which come from the prescaled master clock.

## Interface
Parameters:
- DATA_W, 12, ADC sample width.
- LEAD_ZEROS, 4, zero bits sent before the sample MSB.
- FRAME_LEN, 16, SCK rising edges per complete frame (DATA_W + LEAD_ZEROS).

Ports:
- clk  in  1  system clock; single clock domain. Reset is synchronous, active-high.
- reset  in  1  synchronous active-high reset.
- SCK  in  1  SPI clock from master, asynchronous.
- CS  in  1  chip select from master, active-low, asynchronous.
- MOSI  in  1  master data, asynchronous.
- MISO  out  1  responder data, MSB first.
- sample_data  in  DATA_W  next sample to transmit.
- sample_valid  in  1  sample_data offered.
- sample_ready  out  1  holding register empty; a write is accepted when valid && ready.
- busy  out  1  frame in progress.
- frame_done  out  1  1-cycle pulse on a complete frame.
- rx_data  out  FRAME_LEN  MOSI word of the last complete frame.
- rx_valid  out  1  1-cycle pulse, coincident with frame_done.
- underrun  out  1  1-cycle pulse: frame started with the holding register empty.
- short_frame  out  1  1-cycle pulse: CS rose after fewer than FRAME_LEN rising edges.

## Operation
- Synchronisation:
  - SCK, CS and MOSI each pass through two flops.
  - Edges are detected from the second stage against a third delayed copy.
  - The CS synchroniser resets to 1.
- Arming:
  - After reset, a frame is accepted only after synchronised CS has been seen high for at least 1 cycle.
  - CS held low through reset starts no frame.
- States:
  - IDLE: CS high. MISO=0. busy=0.
  - ACTIVE: entered on a CS falling edge while armed. busy=1.
  - OVER: entered from ACTIVE after FRAME_LEN rising edges. Extra SCK edges shift in zeros. MISO=0.
  - ACTIVE or OVER → IDLE on a CS rising edge.
- Frame start (CS fall):
  - Shift register loads {LEAD_ZEROS zeros, word}. MISO = shift MSB.
  - Holding full: word = holding content; holding is emptied and sample_ready rises the next cycle.
  - Holding empty: word = last_sent; underrun pulses.
- SCK rising edge (ACTIVE): MOSI shifts into the rx shift register; the edge counter increments.
- SCK falling edge (ACTIVE): the tx shift register shifts left and MISO shows the new MSB. The master samples on rising edges.
- CS rise:
  - Edge count == FRAME_LEN: rx_data ← rx shift, and rx_valid and frame_done pulse.
  - Edge count < FRAME_LEN: short_frame pulses and rx_data is unchanged.
  - In both cases last_sent ← word of this frame and the counters clear.
- Holding register:
  - A write while a frame is active is allowed; it feeds the next frame.
  - A write in the same cycle as a frame start is stored and does not bypass into the current frame.
  - sample_valid with ready=0 is ignored; there is no overwrite.
- Reset mid-frame:
  - All state returns to reset values and MISO is 0.
  - The interrupted frame is dropped with no pulses.
  - A new frame requires re-arming.
- Reset values: MISO=0, sample_ready=1, busy=0, frame_done=0, rx_valid=0, underrun=0, short_frame=0, rx_data=0, last_sent=0.

## Timing
- CS fall (pin) → busy=1 and the first MISO bit valid: 3 clk.
- SCK fall (pin) → MISO update: 3 clk.
- SCK rise (pin) → MOSI sample: 3 clk. MOSI must be stable from 1 clk before the SCK rise to 3 clk after it.
- CS rise (pin) → frame_done/rx_valid/short_frame: 3 clk, all 1 cycle wide.
- Each SCK high and low phase must be at least 4 clk. CS high between frames must be at least 4 clk.
- underrun pulses in the same cycle busy rises.
- sample_ready falls the cycle after an accepted write and rises the cycle after a frame start that consumed the holding register.

## Configuration
- SPI_RESP_PATTERN_EN defined:
  - On underrun the frame word is (last_sent + 1) mod 2^DATA_W, which yields an incrementing test ramp.
  - underrun still pulses.
- SPI_RESP_PATTERN_EN undefined: on underrun the frame word is last_sent, repeated.

## Test plan
- Write 0xA5C, then run a 16-edge frame with MOSI=0x8001.
  - MISO bits read on rising edges = 0x0A5C.
  - frame_done and rx_valid pulse once; rx_data=0x8001; underrun=0.
- Two frames with no writes after reset:
  - Default build: both read 0x0000 and underrun pulses twice.
  - With SPI_RESP_PATTERN_EN: reads 0x0001 then 0x0002.
- Write 0x123; raise CS after 9 rising edges.
  - short_frame pulses; rx_data unchanged; frame_done=0.
  - The next frame with no write returns 0x0123 (last_sent) and underrun pulses.
- 20 SCK edges in one frame with word 0xFFF.
  - Edges 1–16 read 0x0FFF; edges 17–20 read 0.
  - Exactly one frame_done.
- Assert reset after 8 edges of a frame while CS stays low.
  - MISO=0; no pulses; busy=0.
  - No frame starts until CS goes high then low; the following full frame completes normally.
- Write 0x111 and start a frame in the same cycle with holding empty.
  - Frame sends last_sent and underrun pulses.
  - The next frame sends 0x111 and sample_ready returns to 1.
